dmem_arbiter: RTL and testbench

//  Shares the single-ported L1 data memory between the core MEM stage and a DMA/loader

---
 rtl/dmem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported L1 data memory between the core MEM stage and a DMA/loader port.
// Latency: grant and memory drive are combinational in the request cycle; response registered, +1 cycle.
// Backpressure: per-cycle ready (core priority, DMA starvation guard, bounded DMA lock); no response backpressure.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_SIZE     = 1024,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  // core MEM stage
  input  logic                  core_valid,
  output logic                  core_ready,
  input  logic                  core_write,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  input  logic [2:0]            core_funct3,
  output logic                  core_rsp_valid,
  output logic [DATA_WIDTH-1:0] core_rsp_rdata,
  output logic                  core_rsp_err,
  // DMA / loader
  input  logic                  dma_valid,
  output logic                  dma_ready,
  input  logic                  dma_write,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  input  logic [2:0]            dma_funct3,
  input  logic                  dma_lock,
  output logic                  dma_rsp_valid,
  output logic [DATA_WIDTH-1:0] dma_rsp_rdata,
  output logic                  dma_rsp_err,
  // data_memory
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [2:0]            mem_funct3,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_SIZE) << 2;

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t   lock_state;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] burst_cnt;

  logic gnt_core, gnt_dma, starve_hit;
  logic err_core, err_dma, sel_err, sel_write;

  logic                  core_rsp_valid_q, dma_rsp_valid_q;
  logic                  core_rsp_err_q, dma_rsp_err_q;
  logic [DATA_WIDTH-1:0] core_rsp_rdata_q, dma_rsp_rdata_q;

  // Rejects misaligned, out-of-range and illegal-size accesses. funct3[1:0] encodes the size;
  // the end address is computed one bit wider so a wrap near the top of the space is still caught.
  function automatic logic access_err(input logic write, input logic [ADDR_WIDTH-1:0] addr,
                                      input logic [2:0] f3);
    logic [ADDR_WIDTH:0] size;
    logic [ADDR_WIDTH:0] end_addr;
    logic                bad;
    case (f3[1:0])
      2'b00:   size = (ADDR_WIDTH + 1)'(1);
      2'b01:   size = (ADDR_WIDTH + 1)'(2);
      default: size = (ADDR_WIDTH + 1)'(4);
    endcase
    bad = 1'b0;
    if (f3[1:0] == 2'b01 && addr[0]) bad = 1'b1;
    if (f3[1:0] == 2'b10 && addr[1:0] != 2'b00) bad = 1'b1;
    end_addr = {1'b0, addr} + size;
    if (end_addr > MEM_BYTES) bad = 1'b1;
    if (write && !(f3 inside {3'b000, 3'b001, 3'b010})) bad = 1'b1;
    if (!write && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) bad = 1'b1;
    return bad;
  endfunction

  assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));
  assign err_core   = access_err(core_write, core_addr, core_funct3);
  assign err_dma    = access_err(dma_write, dma_addr, dma_funct3);

  // Per-cycle grant: an active lock owns the memory, then the starvation guard, then core, then DMA.
  always_comb begin
    gnt_core = 1'b0;
    gnt_dma  = 1'b0;
    if (lock_state == LOCKED)        gnt_dma  = dma_valid;
    else if (starve_hit && dma_valid) gnt_dma  = 1'b1;
    else if (core_valid)             gnt_core = 1'b1;
    else if (dma_valid)              gnt_dma  = 1'b1;
  end

  assign core_ready = gnt_core;
  assign dma_ready  = gnt_dma;

  // Steer the winner onto the memory port; strobes are suppressed for errors and while in reset.
  always_comb begin
    mem_address    = gnt_dma ? dma_addr   : core_addr;
    mem_write_data = gnt_dma ? dma_wdata  : core_wdata;
    mem_funct3     = gnt_dma ? dma_funct3 : core_funct3;
    sel_write      = gnt_dma ? dma_write  : core_write;
    sel_err        = gnt_dma ? err_dma    : err_core;
    mem_read       = (gnt_core || gnt_dma) && !sel_write && !sel_err && !reset;
    mem_write      = (gnt_core || gnt_dma) &&  sel_write && !sel_err && !reset;
  end

  // Starvation counter and DMA lock FSM; a lock ends on release or after MAX_BURST locked cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_state <= UNLOCKED;
      starve_cnt <= '0;
      burst_cnt  <= '0;
    end else begin
      if (!dma_valid || gnt_dma)  starve_cnt <= '0;
      else if (!starve_hit)       starve_cnt <= starve_cnt + SW'(1);

      case (lock_state)
        UNLOCKED: begin
          if (gnt_dma && dma_lock) begin
            lock_state <= LOCKED;
            burst_cnt  <= BW'(1);
          end
        end
        LOCKED: begin
          if (!dma_lock || burst_cnt == BW'(MAX_BURST)) begin
            lock_state <= UNLOCKED;
            burst_cnt  <= '0;
          end else begin
            burst_cnt  <= burst_cnt + BW'(1);
          end
        end
        default: lock_state <= UNLOCKED;
      endcase
    end
  end

  // Capture the response of whichever side was accepted this cycle; load data only for good loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_rsp_valid_q <= 1'b0;
      core_rsp_err_q   <= 1'b0;
      core_rsp_rdata_q <= '0;
      dma_rsp_valid_q  <= 1'b0;
      dma_rsp_err_q    <= 1'b0;
      dma_rsp_rdata_q  <= '0;
    end else begin
      core_rsp_valid_q <= gnt_core;
      core_rsp_err_q   <= gnt_core && err_core;
      core_rsp_rdata_q <= (gnt_core && !core_write && !err_core) ? mem_read_data : '0;
      dma_rsp_valid_q  <= gnt_dma;
      dma_rsp_err_q    <= gnt_dma && err_dma;
      dma_rsp_rdata_q  <= (gnt_dma && !dma_write && !err_dma) ? mem_read_data : '0;
    end
  end

  // A response whose slot overlaps an asserted reset is dropped rather than presented.
  assign core_rsp_valid = core_rsp_valid_q && !reset;
  assign core_rsp_err   = core_rsp_err_q && !reset;
  assign core_rsp_rdata = reset ? '0 : core_rsp_rdata_q;
  assign dma_rsp_valid  = dma_rsp_valid_q && !reset;
  assign dma_rsp_err    = dma_rsp_err_q && !reset;
  assign dma_rsp_rdata  = reset ? '0 : dma_rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed data_memory model behind it.
// Inputs change on the falling edge; outputs are sampled 1 time unit later or at the next falling edge.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_valid, core_ready, core_write;
  logic [31:0] core_addr, core_wdata;
  logic [2:0]  core_funct3;
  logic        core_rsp_valid, core_rsp_err;
  logic [31:0] core_rsp_rdata;
  logic        dma_valid, dma_ready, dma_write, dma_lock;
  logic [31:0] dma_addr, dma_wdata;
  logic [2:0]  dma_funct3;
  logic        dma_rsp_valid, dma_rsp_err;
  logic [31:0] dma_rsp_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [2:0]  mem_funct3;
  logic        mem_read, mem_write;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .core_valid(core_valid), .core_ready(core_ready), .core_write(core_write),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_funct3(core_funct3),
    .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata), .core_rsp_err(core_rsp_err),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_write(dma_write),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_funct3(dma_funct3), .dma_lock(dma_lock),
    .dma_rsp_valid(dma_rsp_valid), .dma_rsp_rdata(dma_rsp_rdata), .dma_rsp_err(dma_rsp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_funct3(mem_funct3),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  // data_memory model: combinational read, little-endian, write on the rising edge
  logic [7:0]  mem_model [0:4095];
  logic [11:0] ma;
  assign ma = mem_address[11:0];

  always_comb begin
    mem_read_data = '0;
    case (mem_funct3)
      3'b000: mem_read_data = {{24{mem_model[ma][7]}}, mem_model[ma]};
      3'b100: mem_read_data = {24'h0, mem_model[ma]};
      3'b001: mem_read_data = {{16{mem_model[ma + 12'd1][7]}}, mem_model[ma + 12'd1], mem_model[ma]};
      3'b101: mem_read_data = {16'h0, mem_model[ma + 12'd1], mem_model[ma]};
      3'b010: mem_read_data = {mem_model[ma + 12'd3], mem_model[ma + 12'd2],
                               mem_model[ma + 12'd1], mem_model[ma]};
      default: mem_read_data = '0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      mem_model[ma] <= mem_write_data[7:0];
      if (mem_funct3 != 3'b000) mem_model[ma + 12'd1] <= mem_write_data[15:8];
      if (mem_funct3 == 3'b010) begin
        mem_model[ma + 12'd2] <= mem_write_data[23:16];
        mem_model[ma + 12'd3] <= mem_write_data[31:24];
      end
    end
  end

  task automatic idle_inputs();
    core_valid = 0; core_write = 0; core_addr = 0; core_wdata = 0; core_funct3 = 3'b010;
    dma_valid = 0; dma_write = 0; dma_addr = 0; dma_wdata = 0; dma_funct3 = 3'b010; dma_lock = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    core_valid = 1; core_write = 0; core_addr = 32'h10; core_funct3 = 3'b010;
    @(negedge clk); #1;
    vec_cnt++;
    if (mem_read !== 1'b0) begin err_cnt++; $display("FAIL reset_mem_read got=%b exp=0", mem_read); end
    vec_cnt++;
    if (core_rsp_valid !== 1'b0 || dma_rsp_valid !== 1'b0) begin
      err_cnt++; $display("FAIL reset_rsp_valid got core=%b dma=%b exp=0/0", core_rsp_valid, dma_rsp_valid);
    end
    vec_cnt++;
    if (core_rsp_rdata !== 32'h0 || core_rsp_err !== 1'b0) begin
      err_cnt++; $display("FAIL reset_rsp_data got rdata=%h err=%b exp=0/0", core_rsp_rdata, core_rsp_err);
    end
    idle_inputs();
    @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    core_valid = 1; core_write = 1; core_addr = 32'h10; core_wdata = 32'hDEADBEEF; core_funct3 = 3'b010;
    #1;
    vec_cnt++;
    if (core_ready !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h10) begin
      err_cnt++; $display("FAIL sw_drive got rdy=%b wr=%b rd=%b addr=%h exp=1/1/0/00000010",
                          core_ready, mem_write, mem_read, mem_address);
    end
    @(negedge clk);
    core_write = 0;
    vec_cnt++;
    if (core_rsp_valid !== 1'b1 || core_rsp_err !== 1'b0 || core_rsp_rdata !== 32'h0) begin
      err_cnt++; $display("FAIL sw_rsp got v=%b err=%b rdata=%h exp=1/0/00000000",
                          core_rsp_valid, core_rsp_err, core_rsp_rdata);
    end
    #1;
    vec_cnt++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
      err_cnt++; $display("FAIL lw_drive got rd=%b wr=%b exp=1/0", mem_read, mem_write);
    end
    @(negedge clk);
    idle_inputs();
    vec_cnt++;
    if (core_rsp_valid !== 1'b1 || core_rsp_rdata !== 32'hDEADBEEF || dma_rsp_valid !== 1'b0) begin
      err_cnt++; $display("FAIL lw_rsp got v=%b rdata=%h dma_v=%b exp=1/deadbeef/0",
                          core_rsp_valid, core_rsp_rdata, dma_rsp_valid);
    end
    @(negedge clk);
    vec_cnt++;
    if (core_rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rsp_single_pulse got=%b exp=0", core_rsp_valid); end
  endtask

  task automatic test_starvation();
    logic exp_dma;
    core_valid = 1; core_write = 0; core_addr = 32'h0;  core_funct3 = 3'b010;
    dma_valid  = 1; dma_write  = 0; dma_addr  = 32'h20; dma_funct3  = 3'b010;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      #1;
      exp_dma = (cyc == 5);
      vec_cnt++;
      if (dma_ready !== exp_dma || core_ready !== !exp_dma) begin
        err_cnt++; $display("FAIL starve_cycle%0d got core_rdy=%b dma_rdy=%b exp=%b/%b",
                            cyc, core_ready, dma_ready, !exp_dma, exp_dma);
      end
      @(negedge clk);
    end
    idle_inputs();
    vec_cnt++;
    if (core_rsp_valid !== 1'b1 || dma_rsp_valid !== 1'b0) begin
      err_cnt++; $display("FAIL starve_rsp_side got core_v=%b dma_v=%b exp=1/0", core_rsp_valid, dma_rsp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_lock_burst();
    logic exp_dma;
    dma_valid = 1; dma_lock = 1; dma_addr = 32'h20; dma_funct3 = 3'b010;
    #1;
    vec_cnt++;
    if (dma_ready !== 1'b1) begin err_cnt++; $display("FAIL lock_grant got=%b exp=1", dma_ready); end
    @(negedge clk);
    core_valid = 1; core_write = 0; core_addr = 32'h10; core_funct3 = 3'b010;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      #1;
      exp_dma = (cyc <= 8);
      vec_cnt++;
      if (dma_ready !== exp_dma || core_ready !== !exp_dma) begin
        err_cnt++; $display("FAIL lock_cycle%0d got core_rdy=%b dma_rdy=%b exp=%b/%b",
                            cyc, core_ready, dma_ready, !exp_dma, exp_dma);
      end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_errors();
    logic [31:0] t_addr [8];
    logic [2:0]  t_f3   [8];
    logic        t_wr   [8];
    logic        t_err  [8];
    t_addr = '{32'h3, 32'h2, 32'hFFC, 32'h1000, 32'hFFE, 32'hFFF, 32'h8, 32'h8};
    t_f3   = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b101, 3'b000, 3'b100, 3'b011};
    t_wr   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    t_err  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      core_valid = 1; core_addr = t_addr[i]; core_funct3 = t_f3[i]; core_write = t_wr[i];
      core_wdata = 32'h1234_5678;
      #1;
      vec_cnt++;
      if (core_ready !== 1'b1 || mem_read !== (!t_err[i] && !t_wr[i]) || mem_write !== 1'b0) begin
        err_cnt++; $display("FAIL err_drive%0d got rdy=%b rd=%b wr=%b exp=1/%b/0",
                            i, core_ready, mem_read, mem_write, !t_err[i] && !t_wr[i]);
      end
      @(negedge clk);
      vec_cnt++;
      if (core_rsp_valid !== 1'b1 || core_rsp_err !== t_err[i]) begin
        err_cnt++; $display("FAIL err_rsp%0d got v=%b err=%b exp=1/%b", i, core_rsp_valid, core_rsp_err, t_err[i]);
      end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_byte_sign();
    dma_valid = 1; dma_write = 1; dma_addr = 32'h21; dma_wdata = 32'h0000_0080; dma_funct3 = 3'b000;
    #1;
    vec_cnt++;
    if (dma_ready !== 1'b1 || mem_write !== 1'b1 || mem_address !== 32'h21) begin
      err_cnt++; $display("FAIL sb_drive got rdy=%b wr=%b addr=%h exp=1/1/00000021", dma_ready, mem_write, mem_address);
    end
    @(negedge clk);
    idle_inputs();
    vec_cnt++;
    if (dma_rsp_valid !== 1'b1 || dma_rsp_err !== 1'b0 || dma_rsp_rdata !== 32'h0) begin
      err_cnt++; $display("FAIL sb_rsp got v=%b err=%b rdata=%h exp=1/0/00000000",
                          dma_rsp_valid, dma_rsp_err, dma_rsp_rdata);
    end
    core_valid = 1; core_write = 0; core_addr = 32'h21; core_funct3 = 3'b000;
    @(negedge clk);
    core_funct3 = 3'b100;
    vec_cnt++;
    if (core_rsp_rdata !== 32'hFFFF_FF80) begin
      err_cnt++; $display("FAIL lb_sext got=%h exp=ffffff80", core_rsp_rdata);
    end
    @(negedge clk);
    idle_inputs();
    vec_cnt++;
    if (core_rsp_rdata !== 32'h0000_0080) begin
      err_cnt++; $display("FAIL lbu_zext got=%h exp=00000080", core_rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_drop();
    dma_valid = 1; dma_lock = 1; dma_write = 0; dma_addr = 32'h20; dma_funct3 = 3'b010;
    @(negedge clk);
    dma_valid = 0;
    core_valid = 1; core_write = 0; core_addr = 32'h10; core_funct3 = 3'b010;
    #1;
    vec_cnt++;
    if (core_ready !== 1'b0) begin err_cnt++; $display("FAIL locked_core_denied got=%b exp=0", core_ready); end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    dma_valid = 1;
    #1;
    vec_cnt++;
    if (core_ready !== 1'b1 || dma_ready !== 1'b0) begin
      err_cnt++; $display("FAIL post_reset_grant got core_rdy=%b dma_rdy=%b exp=1/0", core_ready, dma_ready);
    end
    @(negedge clk);
    reset = 1;
    idle_inputs();
    #1;
    vec_cnt++;
    if (core_rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL drop_rsp_in_reset got=%b exp=0", core_rsp_valid); end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    vec_cnt++;
    if (core_rsp_valid !== 1'b0 || dma_rsp_valid !== 1'b0) begin
      err_cnt++; $display("FAIL drop_rsp_after got core_v=%b dma_v=%b exp=0/0", core_rsp_valid, dma_rsp_valid);
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    test_reset();
    test_store_load();
    test_starvation();
    test_lock_burst();
    test_errors();
    test_byte_sign();
    test_reset_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
